// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encodings and helpers for lcd_hex_driver.
//   - HD44780 command bytes, init nibbles, frame/config lengths
//   - top-level and nibble-writer state enums
//   - hex_ascii: 4-bit value -> upper-case ASCII hex digit
// Optional feature macro: LCD_PC_LINE_EN (adds a second line showing PC).
package lcd_pkg;

    localparam logic [7:0] FUNC_SET = 8'h28;
    localparam logic [7:0] DISP_ON  = 8'h0C;
    localparam logic [7:0] ENTRY    = 8'h06;
    localparam logic [7:0] CLEAR    = 8'h01;
    localparam logic [7:0] LINE1    = 8'h80;
    localparam logic [7:0] LINE2    = 8'hC0;

    // 8-bit-mode wake-up nibble (sent three times), then switch to 4-bit mode
    localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
    localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

    localparam int unsigned INIT_NIBBLES = 4;
    localparam int unsigned CFG_BYTES    = 4;
`ifdef LCD_PC_LINE_EN
    localparam int unsigned FRAME_BYTES  = 18;
`else
    localparam int unsigned FRAME_BYTES  = 9;
`endif

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_CFG,
        S_FRAME,
        S_IDLE
    } lcd_state_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_SETUP,
        W_EHI,
        W_ELO,
        W_WAIT
    } wr_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] d);
        if (d < 4'd10) begin
            return {4'h3, d};
        end
        return 8'h37 + {4'h0, d};
    endfunction

    function automatic logic [3:0] init_nibble(input logic [1:0] idx);
        return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
    endfunction

    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return FUNC_SET;
            2'd1:    return DISP_ON;
            2'd2:    return ENTRY;
            default: return CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_hex_driver_if.sv
// lcd_hex_driver_if: handshake between the byte sequencer (master) and the
// nibble writer (slave), plus the LCD pin values the writer produces.
//   start/rs/nibble/wait_cyc : request one nibble strobe followed by a wait
//   done                     : last cycle of the current strobe + wait
//   lcd_e/lcd_rs/lcd_data    : registered LCD pin values
interface lcd_hex_driver_if;
    logic        start;
    logic        rs;
    logic [3:0]  nibble;
    logic [31:0] wait_cyc;
    logic        done;
    logic        lcd_e;
    logic        lcd_rs;
    logic [3:0]  lcd_data;

    modport master (
        output start, rs, nibble, wait_cyc,
        input  done, lcd_e, lcd_rs, lcd_data
    );

    modport slave (
        input  start, rs, nibble, wait_cyc,
        output done, lcd_e, lcd_rs, lcd_data
    );
endinterface

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: one HD44780 nibble strobe per start request.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : start/rs/nibble/wait_cyc in; done, lcd_e/lcd_rs/lcd_data out
// Sequence: 1 setup cycle (E=0), E_CYC cycles E=1, E_CYC cycles E=0, then
// wait_cyc cycles. done is combinational in the final cycle so the caller can
// start the next nibble with no gap; RS/DATA hold until the next setup.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYC = 25
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    lcd_hex_driver_if.slave  bus
);

    localparam logic [31:0] E_LAST = 32'(E_CYC - 1);

    wr_state_e   state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] wait_q, wait_d;
    logic        e_q, e_d;
    logic        rs_q, rs_d;
    logic [3:0]  data_q, data_d;
    logic        done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 32'd1;
        wait_d  = wait_q;
        e_d     = e_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done    = 1'b0;

        case (state_q)
            W_SETUP: begin
                state_d = W_EHI;
                e_d     = 1'b1;
                cnt_d   = '0;
            end
            W_EHI: begin
                if (cnt_q == E_LAST) begin
                    state_d = W_ELO;
                    e_d     = 1'b0;
                    cnt_d   = '0;
                end
            end
            W_ELO: begin
                if (cnt_q == E_LAST) begin
                    cnt_d = '0;
                    if (wait_q == '0) begin
                        done    = 1'b1;
                        state_d = W_IDLE;
                    end else begin
                        state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (cnt_q == wait_q - 32'd1) begin
                    done    = 1'b1;
                    state_d = W_IDLE;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase

        if (bus.start) begin
            state_d = W_SETUP;
            cnt_d   = '0;
            e_d     = 1'b0;
            rs_d    = bus.rs;
            data_d  = bus.nibble;
            wait_d  = bus.wait_cyc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= W_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign bus.done     = done;
    assign bus.lcd_e    = e_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_data = data_q;

endmodule

// File: rtl/lcd_hex_driver.sv
// lcd_hex_driver: shows Result as eight hex digits on a 16x2 HD44780 LCD in
// 4-bit mode, with power-up init and a periodic refresh loop.
//   CLK, RST           : clock, asynchronous active-low reset
//   Result, PC         : value to display; PC shown on line 2 only when
//                        LCD_PC_LINE_EN is defined
//   LCD_E/RS/RW/DATA   : LCD pins (RW tied low, DATA = DB7..DB4)
//   Ready              : init complete (sticky until reset)
//   FrameDone          : one-cycle pulse after the last character of a frame
// Optional feature macro: LCD_PC_LINE_EN.
module lcd_hex_driver
    import lcd_pkg::*;
#(
    parameter int unsigned E_CYC       = 25,
    parameter int unsigned CMD_CYC     = 2500,
    parameter int unsigned CLR_CYC     = 100000,
    parameter int unsigned INIT_CYC    = 250000,
    parameter int unsigned POWERUP_CYC = 1000000,
    parameter int unsigned REFRESH_CYC = 2500000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Result,
    input  logic [31:0] PC,
    output logic        LCD_E,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic [3:0]  LCD_DATA,
    output logic        Ready,
    output logic        FrameDone
);

    localparam logic [31:0] PWRUP_LAST   = 32'(POWERUP_CYC - 1);
    localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);
    localparam logic [5:0]  INIT_STEPS   = 6'(INIT_NIBBLES);
    localparam logic [5:0]  CFG_STEPS    = 6'(2 * CFG_BYTES);
    localparam logic [5:0]  FRAME_STEPS  = 6'(2 * FRAME_BYTES);

    lcd_hex_driver_if wr_if ();

    lcd_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [5:0]  step_q, step_d;      // index of the next nibble to issue
    logic        ready_q, ready_d;
    logic        fd_q, fd_d;
    logic [31:0] res_q, res_d;

    logic        start;
    logic        nib_rs;
    logic [3:0]  nib;
    logic [31:0] nib_wait;
    logic [7:0]  cfg_b;
    logic [7:0]  fr_b;
    logic        fr_rs;
    logic [4:0]  fb_idx;
    logic [2:0]  dsel_res;

`ifdef LCD_PC_LINE_EN
    logic [31:0] pc_q, pc_d;
    logic [2:0]  dsel_pc;
`else
    logic        pc_unused;
    assign pc_unused = ^PC;
`endif

    // Frame byte for the nibble index in step_q; digits are MSB first, so
    // byte b shows nibble (8-b) mod 8, i.e. -b mod 8.
    always_comb begin
        fb_idx   = step_q[5:1];
        dsel_res = 3'd0 - fb_idx[2:0];
        fr_b     = LINE1;
        fr_rs    = 1'b0;
`ifdef LCD_PC_LINE_EN
        dsel_pc  = 3'd1 - fb_idx[2:0];
`endif
        if (fb_idx >= 5'd1 && fb_idx <= 5'd8) begin
            fr_b  = hex_ascii(res_q[{dsel_res, 2'b00} +: 4]);
            fr_rs = 1'b1;
        end
`ifdef LCD_PC_LINE_EN
        else if (fb_idx == 5'd9) begin
            fr_b = LINE2;
        end else if (fb_idx >= 5'd10) begin
            fr_b  = hex_ascii(pc_q[{dsel_pc, 2'b00} +: 4]);
            fr_rs = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = step_q;
        ready_d  = ready_q;
        fd_d     = 1'b0;
        res_d    = res_q;
`ifdef LCD_PC_LINE_EN
        pc_d     = pc_q;
`endif
        start    = 1'b0;
        nib_rs   = 1'b0;
        nib      = '0;
        nib_wait = '0;
        cfg_b    = cfg_byte(step_q[2:1]);

        case (state_q)
            S_PWRUP: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == PWRUP_LAST) begin
                    start    = 1'b1;
                    nib      = init_nibble(2'd0);
                    nib_wait = 32'(INIT_CYC);
                    step_d   = 6'd1;
                    state_d  = S_INIT;
                end
            end
            S_INIT: begin
                if (wr_if.done) begin
                    start  = 1'b1;
                    step_d = step_q + 6'd1;
                    if (step_q < INIT_STEPS) begin
                        nib      = init_nibble(step_q[1:0]);
                        nib_wait = 32'(INIT_CYC);
                    end else begin
                        nib     = FUNC_SET[7:4];
                        step_d  = 6'd1;
                        state_d = S_CFG;
                    end
                end
            end
            S_CFG: begin
                if (wr_if.done) begin
                    start = 1'b1;
                    if (step_q < CFG_STEPS) begin
                        step_d = step_q + 6'd1;
                        if (step_q[0]) begin
                            nib      = cfg_b[3:0];
                            nib_wait = (cfg_b == CLEAR) ? 32'(CLR_CYC) : 32'(CMD_CYC);
                        end else begin
                            nib = cfg_b[7:4];
                        end
                    end else begin
                        // Clear wait just ended: this is the LINE1 setup cycle.
                        ready_d = 1'b1;
                        nib     = LINE1[7:4];
                        res_d   = Result;
`ifdef LCD_PC_LINE_EN
                        pc_d    = PC;
`endif
                        step_d  = 6'd1;
                        state_d = S_FRAME;
                    end
                end
            end
            S_FRAME: begin
                if (wr_if.done) begin
                    if (step_q < FRAME_STEPS) begin
                        start  = 1'b1;
                        nib_rs = fr_rs;
                        step_d = step_q + 6'd1;
                        if (step_q[0]) begin
                            nib      = fr_b[3:0];
                            nib_wait = 32'(CMD_CYC);
                        end else begin
                            nib = fr_b[7:4];
                        end
                    end else begin
                        fd_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == REFRESH_LAST) begin
                    start   = 1'b1;
                    nib     = LINE1[7:4];
                    res_d   = Result;
`ifdef LCD_PC_LINE_EN
                    pc_d    = PC;
`endif
                    step_d  = 6'd1;
                    state_d = S_FRAME;
                end
            end
            default: begin
                state_d = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_PWRUP;
            cnt_q   <= '0;
            step_q  <= '0;
            ready_q <= 1'b0;
            fd_q    <= 1'b0;
            res_q   <= '0;
`ifdef LCD_PC_LINE_EN
            pc_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            ready_q <= ready_d;
            fd_q    <= fd_d;
            res_q   <= res_d;
`ifdef LCD_PC_LINE_EN
            pc_q    <= pc_d;
`endif
        end
    end

    assign wr_if.start    = start;
    assign wr_if.rs       = nib_rs;
    assign wr_if.nibble   = nib;
    assign wr_if.wait_cyc = nib_wait;

    lcd_nibble_writer #(
        .E_CYC (E_CYC)
    ) u_writer (
        .clk_i  (CLK),
        .rst_ni (RST),
        .bus    (wr_if)
    );

    assign LCD_E     = wr_if.lcd_e;
    assign LCD_RS    = wr_if.lcd_rs;
    assign LCD_DATA  = wr_if.lcd_data;
    assign LCD_RW    = 1'b0;
    assign Ready     = ready_q;
    assign FrameDone = fd_q;

endmodule

// File: tb/tb_lcd_hex_driver.sv
// tb_lcd_hex_driver: directed bench for lcd_hex_driver with short timing
// parameters. A negedge monitor captures nibbles on E falling edges and checks
// strobe timing; scenario tasks compare captured traffic to hand-built values.
// Line-2 checks are compiled in when LCD_PC_LINE_EN is defined.
module tb_lcd_hex_driver;

    localparam int unsigned E_CYC       = 2;
    localparam int unsigned CMD_CYC     = 4;
    localparam int unsigned CLR_CYC     = 8;
    localparam int unsigned INIT_CYC    = 6;
    localparam int unsigned POWERUP_CYC = 10;
    localparam int unsigned REFRESH_CYC = 20;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Result = 32'h1234ABCD;
    logic [31:0] PC = 32'h00400010;
    logic        LCD_E, LCD_RS, LCD_RW;
    logic [3:0]  LCD_DATA;
    logic        Ready, FrameDone;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    lcd_hex_driver_if mon_if ();
    assign mon_if.start    = 1'b0;
    assign mon_if.rs       = 1'b0;
    assign mon_if.nibble   = '0;
    assign mon_if.wait_cyc = '0;
    assign mon_if.done     = 1'b0;
    assign mon_if.lcd_e    = LCD_E;
    assign mon_if.lcd_rs   = LCD_RS;
    assign mon_if.lcd_data = LCD_DATA;

    lcd_hex_driver #(
        .E_CYC       (E_CYC),
        .CMD_CYC     (CMD_CYC),
        .CLR_CYC     (CLR_CYC),
        .INIT_CYC    (INIT_CYC),
        .POWERUP_CYC (POWERUP_CYC),
        .REFRESH_CYC (REFRESH_CYC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Result    (Result),
        .PC        (PC),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA),
        .Ready     (Ready),
        .FrameDone (FrameDone)
    );

    always #5 CLK = ~CLK;

    // ---------------- monitor: capture + strobe timing ----------------
    logic [4:0] nq[$];
    logic       prev_e = 1'b0;
    logic [4:0] prev_bus = '0;
    int         hi_run = 0;
    bit         need_rise = 1'b0;

    always @(negedge CLK) begin
        n_checks++;
        if (LCD_RW !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_low: LCD_RW=%b required 0", LCD_RW);
        end
        if (!RST) begin
            prev_e    = 1'b0;
            prev_bus  = '0;
            hi_run    = 0;
            need_rise = 1'b0;
        end else begin
            if (FrameDone === 1'b1) fd_cnt++;
            if (need_rise) begin
                n_checks++;
                if (mon_if.lcd_e !== 1'b1) begin
                    n_fail++;
                    $display("FAIL setup_len: E=%b one cycle after bus change, required 1", mon_if.lcd_e);
                end
                need_rise = 1'b0;
            end
            if ({mon_if.lcd_rs, mon_if.lcd_data} !== prev_bus) begin
                n_checks++;
                if (mon_if.lcd_e !== 1'b0 || prev_e !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bus_stable: RS/DATA changed to %h with E=%b prevE=%b, required E low",
                             {mon_if.lcd_rs, mon_if.lcd_data}, mon_if.lcd_e, prev_e);
                end
                need_rise = 1'b1;
            end
            if (mon_if.lcd_e === 1'b1) hi_run++;
            if (prev_e === 1'b1 && mon_if.lcd_e === 1'b0) begin
                n_checks++;
                if (hi_run != E_CYC) begin
                    n_fail++;
                    $display("FAIL e_high: E high %0d cycles, required %0d", hi_run, E_CYC);
                end
                nq.push_back({mon_if.lcd_rs, mon_if.lcd_data});
                hi_run = 0;
            end
            prev_e   = mon_if.lcd_e;
            prev_bus = {mon_if.lcd_rs, mon_if.lcd_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Pops the next captured nibble {rs,data}; ok=0 if none arrives in time.
    task automatic get_nib(output logic [4:0] v, output bit ok);
        ok = 1'b0;
        v  = 'x;
        for (int i = 0; i < 400; i++) begin
            if (nq.size() > 0) begin
                v  = nq.pop_front();
                ok = 1'b1;
                return;
            end
            @(negedge CLK);
            #1;
        end
    endtask

    // Releases reset and checks power-up delay, init + config traffic, Ready.
    task automatic release_and_check_init(input string tag);
        logic [3:0] exp_nib[12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
        logic [4:0] v;
        bit         ok;
        int         k;
        @(negedge CLK);
        nq.delete();
        RST = 1'b1;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (LCD_E === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k != POWERUP_CYC + 1) begin
            n_fail++;
            $display("FAIL %s first_e_rise: cycle %0d required %0d", tag, k, POWERUP_CYC + 1);
        end
        for (int i = 0; i < 12; i++) begin
            get_nib(v, ok);
            n_checks++;
            if (!ok || v !== {1'b0, exp_nib[i]}) begin
                n_fail++;
                $display("FAIL %s init_nib[%0d]: got %h required %h", tag, i, v, {1'b0, exp_nib[i]});
            end
        end
        n_checks++;
        if (Ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_early: Ready=%b required 0 during clear wait", tag, Ready);
        end
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (Ready === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k != E_CYC + CLR_CYC) begin
            n_fail++;
            $display("FAIL %s ready_rise: after %0d cycles required %0d", tag, k, E_CYC + CLR_CYC);
        end
        n_checks++;
        if ({LCD_E, LCD_RS, LCD_DATA} !== {1'b0, 1'b0, 4'h8}) begin
            n_fail++;
            $display("FAIL %s line1_setup: E/RS/DATA=%h required %h", tag, {LCD_E, LCD_RS, LCD_DATA}, {1'b0, 1'b0, 4'h8});
        end
    endtask

    // Checks one full frame; optionally changes Result after the 2nd character.
    task automatic expect_frame(input string tag, input string line1, input string line2,
                                input bit chg, input logic [31:0] chg_val);
        logic [4:0] hi, lo;
        logic [7:0] eb;
        bit         ok1, ok2;
        int         fd0, k;
        fd0 = fd_cnt;
        get_nib(hi, ok1);
        get_nib(lo, ok2);
        n_checks++;
        if (!(ok1 && ok2) || {hi, lo} !== 10'b0_1000_0_0000) begin
            n_fail++;
            $display("FAIL %s line1_cmd: got %h/%h required 08/00", tag, hi, lo);
        end
        for (int i = 0; i < 8; i++) begin
            get_nib(hi, ok1);
            get_nib(lo, ok2);
            if (chg && i == 1) Result = chg_val;
            eb = line1[i];
            n_checks++;
            if (!(ok1 && ok2) || {hi, lo} !== {1'b1, eb[7:4], 1'b1, eb[3:0]}) begin
                n_fail++;
                $display("FAIL %s char1[%0d]: got %h/%h required %h (RS=1)", tag, i, hi, lo, eb);
            end
        end
`ifdef LCD_PC_LINE_EN
        get_nib(hi, ok1);
        get_nib(lo, ok2);
        n_checks++;
        if (!(ok1 && ok2) || {hi, lo} !== 10'b0_1100_0_0000) begin
            n_fail++;
            $display("FAIL %s line2_cmd: got %h/%h required 0C/00", tag, hi, lo);
        end
        for (int i = 0; i < 8; i++) begin
            get_nib(hi, ok1);
            get_nib(lo, ok2);
            eb = line2[i];
            n_checks++;
            if (!(ok1 && ok2) || {hi, lo} !== {1'b1, eb[7:4], 1'b1, eb[3:0]}) begin
                n_fail++;
                $display("FAIL %s char2[%0d]: got %h/%h required %h (RS=1)", tag, i, hi, lo, eb);
            end
        end
`else
        if (line2.len() != 8) $display("note: line2 text unused in this build");
`endif
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK);
            #1;
            if (FrameDone === 1'b1) begin
                k = i;
                break;
            end
        end
        n_checks++;
        if (k != E_CYC + CMD_CYC) begin
            n_fail++;
            $display("FAIL %s framedone_time: after %0d cycles required %0d", tag, k, E_CYC + CMD_CYC);
        end
        @(posedge CLK);
        #1;
        n_checks++;
        if (FrameDone !== 1'b0) begin
            n_fail++;
            $display("FAIL %s framedone_width: FrameDone=%b required 0", tag, FrameDone);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (fd_cnt - fd0 != 1) begin
            n_fail++;
            $display("FAIL %s framedone_count: %0d pulses required 1", tag, fd_cnt - fd0);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++;
        if ({LCD_E, LCD_RS, LCD_RW, LCD_DATA, Ready, FrameDone} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 000000000",
                     {LCD_E, LCD_RS, LCD_RW, LCD_DATA, Ready, FrameDone});
        end
        release_and_check_init("por");
    endtask

    task automatic test_frame;
        expect_frame("frame_1234ABCD", "1234ABCD", "00400010", 1'b0, '0);
    endtask

    task automatic test_midframe_change;
        Result = 32'hDEADBEEF;
        expect_frame("frame_DEADBEEF", "DEADBEEF", "00400010", 1'b1, 32'h0);
        expect_frame("frame_zero", "00000000", "00400010", 1'b0, '0);
    endtask

    task automatic test_reset_midframe;
        logic [4:0] v;
        bit         ok;
        bit         hit;
        for (int i = 0; i < 6; i++) get_nib(v, ok);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (LCD_E === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL third_byte_strobe: E=%b never rose, required 1", LCD_E);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if ({LCD_E, LCD_RS, LCD_RW, LCD_DATA, Ready, FrameDone} !== 9'b0) begin
            n_fail++;
            $display("FAIL async_reset: got %b required 000000000",
                     {LCD_E, LCD_RS, LCD_RW, LCD_DATA, Ready, FrameDone});
        end
        repeat (3) @(posedge CLK);
        release_and_check_init("rerun");
        expect_frame("frame_after_reset", "00000000", "00400010", 1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_midframe_change();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_hex_driver.md
# lcd_hex_driver

Character-LCD back end for the single-cycle MIPS board build. It takes the 32-bit value chosen by the display-select stage (`Result`) and drives an HD44780-compatible 16x2 module in 4-bit mode, showing the value as eight upper-case hex digits. It sits directly downstream of the display-select stage and is the last block before the board pins. It owns the power-up init sequence, the E-strobe timing and a periodic refresh loop.

## Interface
Parameters (all counts in CLK cycles):
- `E_CYC`, 25: E high time, also E low time after each strobe.
- `CMD_CYC`, 2500: wait after every byte except clear.
- `CLR_CYC`, 100000: wait after the clear command (0x01).
- `INIT_CYC`, 250000: wait after each of the four init nibbles.
- `POWERUP_CYC`, 1000000: idle time after reset before the first nibble.
- `REFRESH_CYC`, 2500000: idle time between frames.

Ports:
- `CLK` in 1: system clock.
- `RST` in 1: asynchronous, active-low reset.
- `Result` in 32: value to display.
- `PC` in 32: program counter; used only with `LCD_PC_LINE_EN`.
- `LCD_E` out 1: enable strobe.
- `LCD_RS` out 1: 0 = command, 1 = data.
- `LCD_RW` out 1: tied to 0 (write only).
- `LCD_DATA` out 4: DB7..DB4.
- `Ready` out 1: 1 once init is complete; stays 1 until reset.
- `FrameDone` out 1: one-cycle pulse after the last character of each frame.

## Operation
- Reset values: `LCD_E`=0, `LCD_RS`=0, `LCD_RW`=0, `LCD_DATA`=0, `Ready`=0, `FrameDone`=0. The FSM enters PWRUP.
- PWRUP: stay for `POWERUP_CYC` cycles, then go to INIT.
- INIT: send single nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. Each nibble is followed by an `INIT_CYC` wait.
- CFG: send bytes 0x28, 0x0C and 0x06, each followed by a `CMD_CYC` wait. Then send 0x01, followed by a `CLR_CYC` wait. Assert `Ready`, then go to FRAME.
- FRAME:
  - Send command 0x80 and snapshot `Result` (and `PC`) into an internal register.
  - Send 8 data bytes (RS=1), digit 7 (bits 31:28) first.
  - Pulse `FrameDone` in the cycle after the last wait ends.
  - Go to IDLE.
- IDLE: stay for `REFRESH_CYC` cycles, then return to FRAME. The loop runs forever.
- Hex to ASCII: 0–9 map to 0x30–0x39; A–F map to 0x41–0x46.
- Bytes are sent high nibble first, then low nibble. There is no gap between the two nibbles; only the byte's post-wait follows the low nibble.
- `Result` changes mid-frame are ignored. Only the snapshot is displayed.
- `RST` asserted at any time clears everything asynchronously. Deassertion restarts from PWRUP, including the full init.

## Timing
- One nibble strobe lasts 1+2·`E_CYC` cycles:
  - 1 setup cycle: E=0, RS/DATA valid.
  - `E_CYC` cycles with E=1.
  - `E_CYC` cycles with E=0.
- RS/DATA stay stable from the setup cycle through the end of any following wait. They change only in the next setup cycle.
- A byte costs 2·(1+2·`E_CYC`) cycles plus its post-wait.
- The first setup cycle occurs exactly `POWERUP_CYC` cycles after `RST` deasserts.
- The snapshot is taken in the setup cycle of the high nibble of 0x80.
- `Ready` rises in the cycle the `CLR_CYC` wait ends. That same cycle is the 0x80 setup cycle.
- `FrameDone` is high for exactly 1 cycle per frame.
- Frame period is 9 bytes (18 with the macro), plus their waits, plus `REFRESH_CYC`.

## Configuration
- `LCD_PC_LINE_EN` defined:
  - After the 8 `Result` characters, send command 0xC0 and then 8 hex characters of the `PC` snapshot, MSB first.
  - `FrameDone` follows the 16th character.
- `LCD_PC_LINE_EN` undefined:
  - Line 2 is never addressed.
  - The `PC` port exists but is unused.

## Structure
- `lcd_pkg` holds:
  - Command constants: FUNC_SET=0x28, DISP_ON=0x0C, ENTRY=0x06, CLEAR=0x01, LINE1=0x80, LINE2=0xC0.
  - The init nibble constants.
  - The FSM state enum.
  - The `hex_ascii` function (4-bit input, 8-bit output).
- One sub-module, `lcd_nibble_writer`:
  - Accepts a start pulse with rs, nibble and wait count.
  - Performs the setup/E-high/E-low/wait sequence.
  - Returns `done`.
- The top-level FSM sequences bytes and characters through this sub-module.

## Test plan
All cases run with `E_CYC`=2, `CMD_CYC`=4, `CLR_CYC`=8, `INIT_CYC`=6, `POWERUP_CYC`=10, `REFRESH_CYC`=20.
- Reset then release: the first E rise is at cycle 11 after release. Nibbles seen on E falling edges are 3,3,3,2, then 2,8,0,C,0,6,0,1 (RS=0). `Ready` rises after the clear wait.
- `Result`=0x1234ABCD: after 0x80, the data bytes captured are 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44 (RS=1). `FrameDone` pulses once.
- Change `Result` from 0xDEADBEEF to 0 mid-frame: the current frame completes as "DEADBEEF"; the next frame shows "00000000".
- Assert `RST` during the third data byte: all outputs go to reset values immediately. After release the full init sequence repeats.
- With `LCD_PC_LINE_EN`, `PC`=0x00400010: after line 1, command 0xC0 is followed by "00400010". `FrameDone` follows the 16th character.
- Timing checker on every strobe: E high for exactly 2 cycles; RS/DATA stable from the setup cycle through the end of the wait; `LCD_RW` always 0.
